// File: rtl/stream_pkt_arbiter.sv
// stream_pkt_arbiter
// Shares one downstream valid/ready stream between N_PORTS upstream sources.
// Arbitration is round-robin and per packet: once a port is granted, it owns
// the output until its last beat handshakes. m_id_o reports the granted port.
// Optional build macro STREAM_PKT_ARB_STATS_EN adds pkt_cnt_o, a set of
// per-port completed-packet counters.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | outputs quiet, pick the next valid port after ptr (1 cycle)
// LOCKED | pass-through of the granted port until its last beat handshakes

module stream_pkt_arbiter #(
    parameter int T_DATA_WIDTH = 32,
    parameter int N_PORTS      = 4,
    parameter int ID_WIDTH     = $clog2(N_PORTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_PORTS-1:0][T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [N_PORTS-1:0]                     s_last_i,
    input  logic [N_PORTS-1:0]                     s_valid_i,
    output logic [N_PORTS-1:0]                     s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                m_data_o,
    output logic                                   m_last_o,
    output logic                                   m_valid_o,
    input  logic                                   m_ready_i,
    output logic [ID_WIDTH-1:0]                    m_id_o
`ifdef STREAM_PKT_ARB_STATS_EN
    ,
    output logic [N_PORTS-1:0][15:0]               pkt_cnt_o
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, next_state;
    logic [ID_WIDTH-1:0] ptr, next_ptr;
    logic [ID_WIDTH-1:0] grant, next_grant;

    logic                arb_found;
    logic [ID_WIDTH-1:0] arb_sel;
    logic                beat_xfer;
    logic                pkt_done;

    // The granted port only hands over at its last-beat handshake.
    assign beat_xfer = (state == LOCKED) && s_valid_i[grant] && m_ready_i;
    assign pkt_done  = beat_xfer && s_last_i[grant];

    // Round-robin search: first valid port at ptr+1, ptr+2, ... modulo N_PORTS.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!arb_found && s_valid_i[idx]) begin
                arb_found = 1'b1;
                arb_sel   = idx[ID_WIDTH-1:0];
            end
        end
    end

    // State, priority pointer and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= ID_WIDTH'(N_PORTS - 1);
            grant <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            grant <= next_grant;
        end
    end

    // Next-state logic and output mux; ready depends only on state, grant and
    // m_ready_i, so there is no combinational path from any s_valid_i.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_grant = grant;
        s_ready_o  = '0;
        m_data_o   = '0;
        m_last_o   = 1'b0;
        m_valid_o  = 1'b0;
        m_id_o     = grant;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    next_grant = arb_sel;
                    next_state = LOCKED;
                end
            end
            LOCKED: begin
                m_valid_o        = s_valid_i[grant];
                m_data_o         = s_data_i[grant];
                m_last_o         = s_last_i[grant];
                s_ready_o[grant] = m_ready_i;
                if (pkt_done) begin
                    next_ptr   = grant;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef STREAM_PKT_ARB_STATS_EN
    // Per-port completed-packet counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_o <= '0;
        end else if (pkt_done) begin
            pkt_cnt_o[grant] <= pkt_cnt_o[grant] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Directed testbench for stream_pkt_arbiter (N_PORTS=4, 32-bit data).
// Inputs are driven 1 time unit after each rising edge, outputs are checked
// 1 time unit later, well away from the next edge.

module tb_stream_pkt_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0][W-1:0] s_data;
    logic [N-1:0]        s_last;
    logic [N-1:0]        s_valid;
    logic [N-1:0]        s_ready;
    logic [W-1:0]        m_data;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;
    logic [IDW-1:0]      m_id;
`ifdef STREAM_PKT_ARB_STATS_EN
    logic [N-1:0][15:0]  pkt_cnt;
`endif

    int tests = 0;
    int fails = 0;

    stream_pkt_arbiter #(
        .T_DATA_WIDTH (W),
        .N_PORTS      (N),
        .ID_WIDTH     (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_id_o    (m_id)
`ifdef STREAM_PKT_ARB_STATS_EN
        ,
        .pkt_cnt_o (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] d, input logic l);
        s_valid[p] = v;
        s_data[p]  = d;
        s_last[p]  = l;
    endtask

    task automatic quiet_all();
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] id);
        chk({tag, ".valid"}, 32'(m_valid), 32'd0);
        chk({tag, ".data"},  m_data,        32'd0);
        chk({tag, ".last"},  32'(m_last),  32'd0);
        chk({tag, ".ready"}, 32'(s_ready), 32'd0);
        chk({tag, ".id"},    32'(m_id),    id);
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic l,
                            input logic [31:0] id, input logic [31:0] rdy);
        chk({tag, ".valid"}, 32'(m_valid), 32'd1);
        chk({tag, ".data"},  m_data,        d);
        chk({tag, ".last"},  32'(m_last),  32'(l));
        chk({tag, ".id"},    32'(m_id),    id);
        chk({tag, ".ready"}, 32'(s_ready), rdy);
    endtask

    initial begin
        logic [N-1:0] hs;
        logic [N-1:0] beat;
        int           exp_port;
        int           ph;
        int           xfers;

        rst     = 1'b1;
        m_ready = 1'b1;
        quiet_all();
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            tick();
            settle();
            chk_idle($sformatf("idle%0d", c), 32'd0);
        end

        // Single requester: port 2, three beats.
        tick();
        drive(2, 1'b1, 32'hA, 1'b0);
        settle();
        chk_idle("p2_arb", 32'd0);
        tick();
        settle();
        chk_beat("p2_b0", 32'hA, 1'b0, 32'd2, 32'b0100);
        tick();
        drive(2, 1'b1, 32'hB, 1'b0);
        settle();
        chk_beat("p2_b1", 32'hB, 1'b0, 32'd2, 32'b0100);
        tick();
        drive(2, 1'b1, 32'hC, 1'b1);
        settle();
        chk_beat("p2_b2", 32'hC, 1'b1, 32'd2, 32'b0100);
        tick();
        drive(2, 1'b0, 32'h0, 1'b0);
        settle();
        chk_idle("p2_done", 32'd2);
`ifdef STREAM_PKT_ARB_STATS_EN
        chk("p2_cnt", 32'(pkt_cnt[2]), 32'd1);
`endif

        // All four ports requesting continuously, 2-beat packets.
        tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        hs   = '0;
        beat = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) beat[i] = ~beat[i];
                drive(i, 1'b1, 32'(i * 16) + 32'(beat[i]), beat[i]);
            end
            settle();
            ph       = c % 3;
            exp_port = (c / 3) % 4;
            if (ph == 0) begin
                chk($sformatf("rr%0d.valid", c), 32'(m_valid), 32'd0);
            end else begin
                chk($sformatf("rr%0d.valid", c), 32'(m_valid), 32'd1);
                chk($sformatf("rr%0d.data", c), m_data, 32'(exp_port * 16 + ph - 1));
                chk($sformatf("rr%0d.last", c), 32'(m_last), 32'(ph == 2));
                chk($sformatf("rr%0d.id", c), 32'(m_id), 32'(exp_port));
            end
            hs = s_valid & s_ready;
        end

        // Backpressure on port 1; port 0 also waiting.
        tick();
        quiet_all();
        drive(1, 1'b1, 32'h100, 1'b0);
        drive(0, 1'b1, 32'hA0, 1'b0);
        m_ready = 1'b1;
        settle();
        chk("bp_arb.valid", 32'(m_valid), 32'd0);
`ifdef STREAM_PKT_ARB_STATS_EN
        chk("rr_cnt0", 32'(pkt_cnt[0]), 32'd2);
        chk("rr_cnt1", 32'(pkt_cnt[1]), 32'd1);
`endif
        xfers = 0;
        tick();
        settle();
        chk_beat("bp_l1", 32'h100, 1'b0, 32'd1, 32'b0010);
        xfers += int'(s_valid[1] & s_ready[1]);
        tick();
        drive(1, 1'b1, 32'h101, 1'b1);
        m_ready = 1'b0;
        settle();
        chk_beat("bp_l2", 32'h101, 1'b1, 32'd1, 32'b0000);
        xfers += int'(s_valid[1] & s_ready[1]);
        tick();
        settle();
        chk_beat("bp_l3", 32'h101, 1'b1, 32'd1, 32'b0000);
        xfers += int'(s_valid[1] & s_ready[1]);
        tick();
        m_ready = 1'b1;
        settle();
        chk_beat("bp_l4", 32'h101, 1'b1, 32'd1, 32'b0010);
        xfers += int'(s_valid[1] & s_ready[1]);
        chk("bp_xfers", 32'(xfers), 32'd2);

        // Gap and contention: port 0 locked, drops valid, port 3 waiting.
        tick();
        drive(1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("gap_arb.valid", 32'(m_valid), 32'd0);
        chk("gap_arb.id", 32'(m_id), 32'd1);
        tick();
        drive(3, 1'b1, 32'h30, 1'b1);
        settle();
        chk_beat("gap_b0", 32'hA0, 1'b0, 32'd0, 32'b0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            drive(0, 1'b0, 32'hA1, 1'b1);
            settle();
            chk($sformatf("gap%0d.valid", c), 32'(m_valid), 32'd0);
            chk($sformatf("gap%0d.id", c), 32'(m_id), 32'd0);
            chk($sformatf("gap%0d.ready", c), 32'(s_ready), 32'b0001);
        end
        tick();
        drive(0, 1'b1, 32'hA1, 1'b1);
        settle();
        chk_beat("gap_b1", 32'hA1, 1'b1, 32'd0, 32'b0001);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        settle();
        chk_idle("gap_done", 32'd0);
        tick();
        settle();
        chk_beat("p3_b0", 32'h30, 1'b1, 32'd3, 32'b1000);

        // Reset in the middle of a port 1 packet.
        tick();
        drive(3, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b1, 32'h110, 1'b0);
        settle();
        chk("rs_arb.valid", 32'(m_valid), 32'd0);
        tick();
        settle();
        chk_beat("rs_b0", 32'h110, 1'b0, 32'd1, 32'b0010);
        tick();
        drive(1, 1'b1, 32'h111, 1'b0);
        rst = 1'b1;
        settle();
        chk_beat("rs_b1", 32'h111, 1'b0, 32'd1, 32'b0010);
        tick();
        rst = 1'b0;
        drive(1, 1'b1, 32'h110, 1'b0);
        drive(0, 1'b1, 32'hB0, 1'b1);
        settle();
        chk_idle("rs_after", 32'd0);
`ifdef STREAM_PKT_ARB_STATS_EN
        chk("rs_cnt1", 32'(pkt_cnt[1]), 32'd0);
        chk("rs_cnt0", 32'(pkt_cnt[0]), 32'd0);
`endif
        tick();
        settle();
        chk_beat("rs_p0", 32'hB0, 1'b1, 32'd0, 32'b0001);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        settle();
        chk_idle("rs_arb2", 32'd0);
        tick();
        settle();
        chk_beat("rs_p1", 32'h110, 1'b0, 32'd1, 32'b0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_pkt_arbiter.md
Name: stream_pkt_arbiter

Overview:
- Shares one downstream valid/ready stream (e.g. the input of a stream_upsize instance) between N upstream requesters.
- Arbitration is round-robin and packet-granular: once a port is granted, it owns the output until its beat with last=1 handshakes.
- Adds an m_id_o sideband so downstream logic knows which source each packet came from.
- Sits between source DMA/stream producers and the width converter.

Parameters:
- T_DATA_WIDTH, 32, width of one data word on every port.
- N_PORTS, 4, number of requesters; legal range 2..16.
- ID_WIDTH, $clog2(N_PORTS), width of m_id_o and grant index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data_i  in  [N_PORTS][T_DATA_WIDTH]  per-port data.
- s_last_i  in  [N_PORTS]  per-port end-of-packet marker.
- s_valid_i  in  [N_PORTS]  per-port valid.
- s_ready_o  out  [N_PORTS]  per-port ready.
- m_data_o  out  T_DATA_WIDTH  muxed data.
- m_last_o  out  1  muxed last.
- m_valid_o  out  1  muxed valid.
- m_ready_i  in  1  downstream ready.
- m_id_o  out  ID_WIDTH  index of the currently granted port.

Behaviour:
- Reset (rst=1 at a posedge), values from the next cycle:
  - state=IDLE, ptr=N_PORTS-1 (port 0 has first priority), grant=0.
  - All s_ready_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=0.
- FSM state IDLE:
  - Outputs are held as in reset, except m_id_o shows the last grant.
  - If any s_valid_i[k]=1, select the first valid port searching ptr+1, ptr+2, ... modulo N_PORTS.
  - Register that index as grant; next state=LOCKED.
  - No input is consumed in IDLE.
  - If no port is valid, stay in IDLE.
- FSM state LOCKED (combinational pass-through of the granted port g):
  - m_valid_o=s_valid_i[g], m_data_o=s_data_i[g], m_last_o=s_last_i[g], m_id_o=g.
  - s_ready_o[g]=m_ready_i; s_ready_o[k]=0 for every k!=g.
  - A beat transfers when s_valid_i[g]&m_ready_i. No other port's data or last ever reaches the output.
  - A transfer with s_last_i[g]=1 sets ptr=g and next state=IDLE.
  - In that IDLE cycle: m_valid_o=0, m_data_o=0, m_last_o=0.
- Latency:
  - 1 arbitration cycle (IDLE) precedes every packet; the first beat can transfer in the cycle after the request is first seen.
  - Maximum throughput is L beats in L+1 cycles for an L-beat packet.
- Fairness: with all ports continuously requesting, grant order is 0,1,2,...,N-1,0,...
- Single-beat packets (first beat already has last=1): LOCKED lasts exactly one cycle if m_ready_i=1.
- Granted port drops valid mid-packet: the lock is held, m_valid_o=0, and no other port is granted (no timeout).
- m_ready_i=0: the granted beat stalls; m_data_o/m_last_o stay stable as long as the source holds them (AXI-stream rules apply to sources).
- A port raising valid while another port is locked: it waits, and is considered at the next IDLE.
- rst during LOCKED: the packet is abandoned mid-stream, no further beats are accepted, and the next grant starts from port 0.
- No combinational path from s_valid_i to s_ready_o. The only comb path through the block is m_ready_i->s_ready_o.

Optional Feature:
- Macro: STREAM_PKT_ARB_STATS_EN.
- When defined, add output pkt_cnt_o [N_PORTS][16]:
  - Per-port count of completed packets (last-beat handshakes).
  - Reset to 0; wraps 16'hFFFF->0.
  - Increments in the same cycle the last beat handshakes; visible on the next cycle.
- When not defined: the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: no s_valid_i for 5 cycles -> m_valid_o=0, all s_ready_o=0, m_id_o=0 throughout.
- Single requester: port 2 sends a 3-beat packet 0xA,0xB,0xC (last on 0xC), m_ready_i=1 -> outputs 0xA,0xB,0xC on the 3 cycles after 1 IDLE cycle, m_id_o=2, m_last_o only on 0xC.
- All 4 ports valid continuously, 2-beat packets with data = port*16+beat -> packet order is ports 0,1,2,3,0; each packet is contiguous; 1 bubble cycle between packets.
- Backpressure: port 1 granted, m_ready_i toggles 1,0,0,1 over 4 cycles with a 2-beat packet -> exactly 2 transfers; data is stable while stalled; s_ready_o[1] mirrors m_ready_i; the other readys stay 0.
- Gap and contention: port 0 granted, drops valid for 3 cycles mid-packet while port 3 is valid -> no output beats and no grant change; port 3 is granted only after port 0's last beat.
- Reset mid-packet: rst asserted during the 2nd beat of port 1 -> next cycle all outputs are 0; after release, with ports 1 and 0 both valid, port 0 is granted first; with STREAM_PKT_ARB_STATS_EN, pkt_cnt_o[1]=0.
